// File: rtl/ls_counter_pkg.sv
// ---------------------------------------------------------------------------
// ls_counter_pkg
//   Shared definitions for the LS-style counter family.
//   LS_CNT_WIDTH : default counter/preset width
//   ls_cnt_op_t  : per-edge operation chosen by the next-state decode
//     OP_HOLD - keep Q
//     OP_LOAD - parallel load of Q and preset from D
//     OP_DEC  - Q decrements by one
//     OP_WRAP - Q was zero while enabled: reload preset or wrap to all-ones
// ---------------------------------------------------------------------------
package ls_counter_pkg;

    localparam int unsigned LS_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_DEC,
        OP_WRAP
    } ls_cnt_op_t;

endpackage

// File: rtl/ls_down_counter.sv
// ---------------------------------------------------------------------------
// ls_down_counter
//   Presettable synchronous binary down counter with cascade enables and a
//   combinational borrow (terminal-zero) output. With AUTO_RELOAD=1 the
//   stored preset is reloaded at zero, giving a divide-by-(PRE+1) tick on
//   ZERO_STB. Stages cascade by wiring RCO of the lower stage to ENT of the
//   next.
//
// Parameters
//   WIDTH        counter/preset width in bits (>=2)
//   AUTO_RELOAD  0: wrap 0 -> all-ones, 1: reload stored preset at zero
//
// Ports
//   CLK       in   rising-edge clock
//   CLR_n     in   asynchronous active-low clear (Q, preset, ZERO_STB)
//   D         in   parallel preset value, sampled only on load
//   LOAD_n    in   synchronous active-low parallel load (highest priority)
//   ENP       in   parallel count enable
//   ENT       in   trickle count enable (cascade input)
//   Q         out  registered counter value
//   RCO       out  borrow: (Q==0) & ENT, combinational
//   ZERO_STB  out  registered one-cycle pulse per enabled zero crossing
// ---------------------------------------------------------------------------
module ls_down_counter
    import ls_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = LS_CNT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             ZERO_STB
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_pre;
    logic             r_zero_stb;
    logic             w_q_zero;
    ls_cnt_op_t       w_op;

    assign w_q_zero = (r_q == '0);

    // Load beats counting, so a load on the terminal-zero edge suppresses
    // both the reload/wrap and the strobe.
    always_comb begin
        w_op = OP_HOLD;
        if (!LOAD_n) begin
            w_op = OP_LOAD;
        end else if (ENP && ENT) begin
            w_op = w_q_zero ? OP_WRAP : OP_DEC;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_q        <= '0;
            r_pre      <= '0;
            r_zero_stb <= 1'b0;
        end else begin
            unique case (w_op)
                OP_LOAD: begin
                    r_q        <= D;
                    r_pre      <= D;
                    r_zero_stb <= 1'b0;
                end
                OP_DEC: begin
                    r_q        <= r_q - 1'b1;
                    r_zero_stb <= 1'b0;
                end
                OP_WRAP: begin
                    r_q        <= AUTO_RELOAD ? r_pre : '1;
                    r_zero_stb <= 1'b1;
                end
                default: begin
                    r_zero_stb <= 1'b0;
                end
            endcase
        end
    end

    assign Q        = r_q;
    // Gated by ENT only so a held upper stage still propagates the borrow;
    // kept combinational so cascaded stages step on the same edge.
    assign RCO      = w_q_zero & ENT;
    assign ZERO_STB = r_zero_stb;

endmodule
